// File: rtl/tx_timer_pkg.sv
// Shared constants and FSM state type for the USB TX bit/byte timer.
package tx_timer_pkg;

    localparam int TX_CLKS_PER_BIT_DEF  = 8;
    localparam int TX_BITS_PER_BYTE_DEF = 8;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } tx_timer_state_t;

endpackage

// File: rtl/flex_counter.sv
// Parametrised up-counter: counts 0..ROLLOVER-1 and wraps; synchronous clear wins over count.
module flex_counter #(
    parameter int NUM_CNT_BITS = 4,
    parameter int ROLLOVER     = 16
) (
    input  logic                    clk,
    input  logic                    n_rst,
    input  logic                    clear,
    input  logic                    count_enable,
    output logic [NUM_CNT_BITS-1:0] count_out
);

    localparam logic [NUM_CNT_BITS-1:0] LAST = NUM_CNT_BITS'(ROLLOVER - 1);

    logic [NUM_CNT_BITS-1:0] r_count;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (count_enable) begin
            r_count <= (r_count == LAST) ? '0 : r_count + NUM_CNT_BITS'(1);
        end
    end

    assign count_out = r_count;

endmodule

// File: rtl/tx_bit_timer.sv
// USB TX bit/byte timer: bit-period divider plus data-bit counter with strobe/byte_done pulses.
// Define TX_BIT_TIMER_STALL_EN to let `stall` hold the bit count on stuffed-bit boundaries.
module tx_bit_timer
    import tx_timer_pkg::*;
#(
    parameter int CLKS_PER_BIT  = TX_CLKS_PER_BIT_DEF,
    parameter int BITS_PER_BYTE = TX_BITS_PER_BYTE_DEF,
    parameter int BW            = $clog2(BITS_PER_BYTE)
) (
    input  logic          clk,
    input  logic          n_rst,
    input  logic          enable,
    input  logic          stall,
    output logic          bit_strobe,
    output logic          byte_done,
    output logic [BW-1:0] bit_index,
    output logic          busy
);

    localparam int                DIV_W    = $clog2(CLKS_PER_BIT);
    localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0]     BIT_LAST = BW'(BITS_PER_BYTE - 1);

    tx_timer_state_t r_state;
    tx_timer_state_t w_state_next;
    logic            r_strobe;
    logic            r_done;
    logic            r_busy;
    logic            w_strobe_next;
    logic            w_done_next;
    logic [DIV_W-1:0] w_clk_cnt;
    logic [BW-1:0]   w_bit_cnt;
    logic            w_boundary;
    logic            w_bit_adv;

    assign w_boundary = enable && (w_clk_cnt == DIV_LAST);

`ifdef TX_BIT_TIMER_STALL_EN
    // A stuffed bit still occupies a line bit time, but is not a data bit.
    assign w_bit_adv = w_boundary && !stall;
`else
    logic w_unused_stall;
    assign w_unused_stall = stall;
    assign w_bit_adv      = w_boundary;
`endif

    flex_counter #(
        .NUM_CNT_BITS (DIV_W),
        .ROLLOVER     (CLKS_PER_BIT)
    ) u_clk_div (
        .clk          (clk),
        .n_rst        (n_rst),
        .clear        (!enable),
        .count_enable (enable),
        .count_out    (w_clk_cnt)
    );

    flex_counter #(
        .NUM_CNT_BITS (BW),
        .ROLLOVER     (BITS_PER_BYTE)
    ) u_bit_cnt (
        .clk          (clk),
        .n_rst        (n_rst),
        .clear        (!enable),
        .count_enable (w_bit_adv),
        .count_out    (w_bit_cnt)
    );

    always_comb begin
        w_state_next  = r_state;
        w_strobe_next = 1'b0;
        w_done_next   = 1'b0;
        case (r_state)
            IDLE:    if (enable)  w_state_next = RUN;
            RUN:     if (!enable) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
        // Dropping enable on a boundary edge suppresses that edge's pulses.
        if (enable) begin
            w_strobe_next = w_boundary;
            w_done_next   = w_bit_adv && (w_bit_cnt == BIT_LAST);
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state  <= IDLE;
            r_strobe <= 1'b0;
            r_done   <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_strobe <= w_strobe_next;
            r_done   <= w_done_next;
            r_busy   <= (w_state_next == RUN);
        end
    end

    assign bit_strobe = r_strobe;
    assign byte_done  = r_done;
    assign bit_index  = w_bit_cnt;
    assign busy       = r_busy;

endmodule

// File: tb/tb_tx_bit_timer.sv
// Directed bench for tx_bit_timer: default build plus a CLKS_PER_BIT=2 / BITS_PER_BYTE=10 instance.
module tb_tx_bit_timer;

    logic       clk;
    logic       n_rst;
    logic       en0, st0, en1, st1;
    logic       s0, d0, b0, s1, d1, b1;
    logic [2:0] i0;
    logic [3:0] i1;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int r       = 0;

    tx_bit_timer u0 (
        .clk        (clk),
        .n_rst      (n_rst),
        .enable     (en0),
        .stall      (st0),
        .bit_strobe (s0),
        .byte_done  (d0),
        .bit_index  (i0),
        .busy       (b0)
    );

    tx_bit_timer #(.CLKS_PER_BIT(2), .BITS_PER_BYTE(10)) u1 (
        .clk        (clk),
        .n_rst      (n_rst),
        .enable     (en1),
        .stall      (st1),
        .bit_strobe (s1),
        .byte_done  (d1),
        .bit_index  (i1),
        .busy       (b1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s cycle %0d: got %0d expected %0d", tag, cyc, obs, exp);
        end
    endtask

    task automatic chk0(input string tag, input logic s, input logic d, input int i, input logic b);
        chk({tag, ".strobe"}, 32'(s0), 32'(s));
        chk({tag, ".done"},   32'(d0), 32'(d));
        chk({tag, ".index"},  32'(i0), 32'(i));
        chk({tag, ".busy"},   32'(b0), 32'(b));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Reference behaviour of u0 for plain enable patterns (no stall).
    task automatic model_step(input string tag, input logic en);
        en0 = en;
        step();
        if (en) begin
            r++;
            chk0(tag, (r % 8) == 0, (r % 64) == 0, (r / 8) % 8, 1'b1);
        end else begin
            r = 0;
            chk0(tag, 1'b0, 1'b0, 0, 1'b0);
        end
    endtask

    task automatic do_reset();
        en0   = 1'b0;
        st0   = 1'b0;
        n_rst = 1'b0;
        step();
        step();
        chk0("rst", 1'b0, 1'b0, 0, 1'b0);
        n_rst = 1'b1;
        cyc   = 0;
        r     = 0;
    endtask

    initial begin
        n_rst = 1'b0;
        en0 = 1'b0; st0 = 1'b0; en1 = 1'b0; st1 = 1'b0;
        #2;
        chk0("por", 1'b0, 1'b0, 0, 1'b0);

        // Free run on both instances.
        do_reset();
        en0 = 1'b1;
        en1 = 1'b1;
        for (int k = 1; k <= 200; k++) begin
            step();
            chk0("run8x8", (k % 8) == 0, (k % 64) == 0, (k / 8) % 8, 1'b1);
            chk("run2x10.strobe", 32'(s1), 32'((k % 2) == 0));
            chk("run2x10.done",   32'(d1), 32'((k % 20) == 0));
            chk("run2x10.index",  32'(i1), 32'((k / 2) % 10));
            chk("run2x10.busy",   32'(b1), 32'(1));
        end
        en1 = 1'b0;

        // Enable low for edges 31..40; restart from a full period.
        do_reset();
        for (int k = 1; k <= 60; k++) model_step("gap", !(k >= 31 && k <= 40));

        // Enable dropped exactly on the boundary edge 16.
        do_reset();
        for (int k = 1; k <= 30; k++) model_step("bdrop", !(k >= 16 && k <= 20));

        // Asynchronous reset in the middle of a byte.
        do_reset();
        for (int k = 1; k <= 36; k++) model_step("prerst", 1'b1);
        #1;
        n_rst = 1'b0;
        #1;
        chk0("async_rst", 1'b0, 1'b0, 0, 1'b0);
        step();
        chk0("held_rst", 1'b0, 1'b0, 0, 1'b0);
        n_rst = 1'b1;
        r = 0;
        #1;
        chk0("release", 1'b0, 1'b0, 0, 1'b0);
        for (int k = 1; k <= 16; k++) model_step("postrst", 1'b1);

        // Stall on the third boundary (edge 24) and on non-boundary edges 9..11.
        do_reset();
        en0 = 1'b1;
        for (int k = 1; k <= 80; k++) begin
            int  adv;
            logic dexp;
            st0 = (k == 24) || (k >= 9 && k <= 11);
            step();
`ifdef TX_BIT_TIMER_STALL_EN
            adv  = (k / 8) - ((k >= 24) ? 1 : 0);
            dexp = ((k % 8) == 0) && (k != 24) && ((adv % 8) == 0);
`else
            adv  = k / 8;
            dexp = (k % 64) == 0;
`endif
            chk0("stall", (k % 8) == 0, dexp, adv % 8, 1'b1);
        end
        st0 = 1'b0;
        en0 = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
